// File: rtl/imem_loader.sv
// Instruction store filled over a valid/ready load stream,
// then served to the fetch port combinationally while in RUN.
// Ports: clk, reset (sync, active-low), i_addr/i_data/i_fault
// fetch read, halted core hold, ld_* load stream, reload, ld_count
// and ld_overflow load status.
module imem_loader #(
  parameter int unsigned Depth      = 1024,
  parameter logic [31:0] BootVector = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              i_addr,
  output logic [31:0]              i_data,
  output logic                     i_fault,
  output logic                     halted,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [31:0]              ld_data,
  input  logic                     ld_last,
  input  logic                     reload,
  output logic [$clog2(Depth):0]   ld_count,
  output logic                     ld_overflow
);

  localparam int          AW     = $clog2(Depth);
  localparam logic [31:0] Nop    = 32'h0000_0013;
  localparam logic [AW-1:0] PtrMax = AW'(Depth - 1);
  localparam logic [33:0] Span   = 34'(Depth) << 2;

  typedef enum logic {
    S_LOAD,
    S_RUN
  } state_e;

  state_e        state_q;
  logic [AW-1:0] ptr_q;
  logic [AW:0]   cnt_q;
  logic          ovf_q;
  logic          halted_q;

  logic [31:0]   mem_q [Depth];

  logic          accept;
  logic          at_end;
  logic [31:0]   off;
  logic          in_rng;
  logic [AW-1:0] rd_idx;

  // ld_ready is a function of state and reload only, never ld_valid.
  assign ld_ready = (state_q == S_LOAD) & ~reload;
  assign accept   = ld_valid & ld_ready;
  assign at_end   = (ptr_q == PtrMax);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_LOAD;
      ptr_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      halted_q <= 1'b1;
    end else if (reload) begin
      state_q  <= S_LOAD;
      ptr_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      halted_q <= 1'b1;
    end else if (accept) begin
      cnt_q <= cnt_q + 1'b1;
      // Pointer saturates at the last word; the FSM leaves LOAD there.
      if (!at_end) begin
        ptr_q <= ptr_q + 1'b1;
      end
      if (ld_last || at_end) begin
        state_q  <= S_RUN;
        halted_q <= 1'b0;
      end
      if (at_end && !ld_last) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Store is never cleared; a beat coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (reset && accept) begin
      mem_q[ptr_q] <= ld_data;
    end
  end

  assign off    = i_addr - BootVector;
  assign in_rng = {2'b00, off} < Span;
  assign rd_idx = off[AW+1:2];

  always_comb begin
    i_data  = Nop;
    i_fault = 1'b0;
    if (state_q == S_RUN) begin
      if (in_rng) begin
        i_data = mem_q[rd_idx];
      end else begin
        i_fault = 1'b1;
      end
    end
  end

  assign halted      = halted_q;
  assign ld_count    = cnt_q;
  assign ld_overflow = ovf_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a Depth=4 instance at boot 0
// and a Depth=16 instance at boot 0x1000 sharing one load stream.
module tb_imem_loader;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        reload;

  logic [31:0] addr_a, data_a;
  logic        fault_a, halted_a, ready_a, ovf_a;
  logic [2:0]  cnt_a;

  logic [31:0] addr_b, data_b;
  logic        fault_b, halted_b, ready_b, ovf_b;
  logic [4:0]  cnt_b;

  int n_tests;
  int n_fail;

  imem_loader #(.Depth(4), .BootVector(32'h0000_0000)) u_a (
    .clk        (clk),
    .reset      (rst_n),
    .i_addr     (addr_a),
    .i_data     (data_a),
    .i_fault    (fault_a),
    .halted     (halted_a),
    .ld_valid   (ld_valid),
    .ld_ready   (ready_a),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .reload     (reload),
    .ld_count   (cnt_a),
    .ld_overflow(ovf_a)
  );

  imem_loader #(.Depth(16), .BootVector(32'h0000_1000)) u_b (
    .clk        (clk),
    .reset      (rst_n),
    .i_addr     (addr_b),
    .i_data     (data_b),
    .i_fault    (fault_b),
    .halted     (halted_b),
    .ld_valid   (ld_valid),
    .ld_ready   (ready_b),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .reload     (reload),
    .ld_count   (cnt_b),
    .ld_overflow(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic rd_a(input string tag, input logic [31:0] a,
                      input logic [31:0] d, input logic f);
    addr_a = a;
    #1;
    chk({tag, ".data"}, data_a, d);
    chk({tag, ".fault"}, 32'(fault_a), 32'(f));
  endtask

  task automatic rd_b(input string tag, input logic [31:0] a,
                      input logic [31:0] d, input logic f);
    addr_b = a;
    #1;
    chk({tag, ".data"}, data_b, d);
    chk({tag, ".fault"}, 32'(fault_b), 32'(f));
  endtask

  task automatic beat(input logic [31:0] d, input logic l);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = l;
    @(negedge clk);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic pulse_reload;
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  logic [31:0] t1 [3];
  logic [31:0] bp [3];

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    ld_valid = 1'b0;
    ld_data  = '0;
    ld_last  = 1'b0;
    reload   = 1'b0;
    addr_a   = '0;
    addr_b   = '0;
    t1[0] = 32'h0050_0093;
    t1[1] = 32'h0010_8113;
    t1[2] = 32'h0000_006F;
    bp[0] = 32'h1111_0001;
    bp[1] = 32'h2222_0002;
    bp[2] = 32'h3333_0003;

    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst.halted", 32'(halted_a), 32'd1);
    chk("rst.ready", 32'(ready_a), 32'd1);
    chk("rst.count", 32'(cnt_a), 32'd0);
    chk("rst.ovf", 32'(ovf_a), 32'd0);
    chk("rst.data", data_a, NOP);
    chk("rst.fault", 32'(fault_a), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t1.halted_in_load", 32'(halted_a), 32'd1);
      beat(t1[i], i == 2);
    end
    #1;
    chk("t1.halted", 32'(halted_a), 32'd0);
    chk("t1.ready", 32'(ready_a), 32'd0);
    chk("t1.count", 32'(cnt_a), 32'd3);
    rd_a("t1.rd4", 32'd4, 32'h0010_8113, 1'b0);
    rd_a("t1.rd0", 32'd0, 32'h0050_0093, 1'b0);
    @(negedge clk);

    addr_a = 32'd4;
    pulse_reload;
    #1;
    chk("rl_run.halted", 32'(halted_a), 32'd1);
    chk("rl_run.ready", 32'(ready_a), 32'd1);
    chk("rl_run.count", 32'(cnt_a), 32'd0);
    chk("rl_run.data", data_a, NOP);
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      ld_valid = (i % 2) == 0;
      ld_data  = ((i % 2) == 0) ? bp[i/2] : 32'hBAD0_0000 + 32'(i);
      ld_last  = (i == 4);
      @(negedge clk);
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    #1;
    chk("bp.halted", 32'(halted_a), 32'd0);
    chk("bp.count", 32'(cnt_a), 32'd3);
    rd_a("bp.w0", 32'd0, bp[0], 1'b0);
    rd_a("bp.w1", 32'd4, bp[1], 1'b0);
    rd_a("bp.w2", 32'd8, bp[2], 1'b0);
    @(negedge clk);

    pulse_reload;
    beat(32'hAAAA_0000, 1'b0);
    ld_valid = 1'b1;
    ld_data  = 32'hDEAD_BEEF;
    reload   = 1'b1;
    #1;
    chk("col.ready", 32'(ready_a), 32'd0);
    @(negedge clk);
    reload   = 1'b0;
    ld_valid = 1'b0;
    #1;
    chk("col.count", 32'(cnt_a), 32'd0);
    chk("col.halted", 32'(halted_a), 32'd1);
    beat(32'hBBBB_0000, 1'b1);
    #1;
    chk("col.count1", 32'(cnt_a), 32'd1);
    rd_a("col.w0", 32'd0, 32'hBBBB_0000, 1'b0);
    rd_a("col.w1", 32'd4, bp[1], 1'b0);
    @(negedge clk);

    pulse_reload;
    for (int i = 0; i < 4; i++) begin
      beat(32'h4444_0000 + 32'(i), 1'b0);
    end
    #1;
    chk("ovf.halted", 32'(halted_a), 32'd0);
    chk("ovf.flag", 32'(ovf_a), 32'd1);
    chk("ovf.ready", 32'(ready_a), 32'd0);
    chk("ovf.count", 32'(cnt_a), 32'd4);
    ld_valid = 1'b1;
    ld_data  = 32'h4444_0004;
    @(negedge clk);
    ld_valid = 1'b0;
    #1;
    chk("ovf.count5", 32'(cnt_a), 32'd4);
    rd_a("ovf.w3", 32'd12, 32'h4444_0003, 1'b0);
    rd_a("ovf.oob", 32'd16, NOP, 1'b1);
    @(negedge clk);

    pulse_reload;
    beat(32'h5555_0000, 1'b0);
    beat(32'h5555_0001, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("mid.count", 32'(cnt_a), 32'd0);
    chk("mid.ovf", 32'(ovf_a), 32'd0);
    chk("mid.halted", 32'(halted_a), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    beat(32'h6666_0000, 1'b0);
    beat(32'h6666_0001, 1'b1);
    #1;
    chk("mid.count2", 32'(cnt_a), 32'd2);
    rd_a("mid.w0", 32'd0, 32'h6666_0000, 1'b0);
    rd_a("mid.w1", 32'd4, 32'h6666_0001, 1'b0);
    rd_a("mid.w2", 32'd8, 32'h4444_0002, 1'b0);
    @(negedge clk);

    pulse_reload;
    for (int i = 0; i < 16; i++) begin
      beat(32'hC000_0000 + 32'(i), i == 15);
    end
    #1;
    chk("oor.halted", 32'(halted_b), 32'd0);
    chk("oor.count", 32'(cnt_b), 32'd16);
    rd_b("oor.below", 32'h0000_0FFC, NOP, 1'b1);
    rd_b("oor.above", 32'h0000_1040, NOP, 1'b1);
    @(negedge clk);
    rd_b("oor.w15", 32'h0000_103C, 32'hC000_000F, 1'b0);
    rd_b("oor.w0", 32'h0000_1000, 32'hC000_0000, 1'b0);
    rd_b("oor.w5", 32'h0000_1016, 32'hC000_0005, 1'b0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory responder on the far end of the fetch stage's `i_addr`/`i_data` port. It holds a register-array instruction store, fills it from a host over a valid/ready load stream, and then serves fetch reads combinationally in the same cycle. While it is loading it holds the core halted, so the pipeline never fetches from a partially written image.

## Interface

Parameters:
- `Depth`, 1024: instruction store size in 32-bit words; power of two, ≥ 2.
- `BootVector`, 32'h0000_0000: byte address that maps to word 0; must match the core's boot vector.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `i_addr`  in  32  fetch byte address.
- `i_data`  out  32  instruction word, combinational from `i_addr`.
- `i_fault`  out  1  `i_addr` is outside the store while in RUN; combinational.
- `halted`  out  1  core halt request; high throughout LOAD.
- `ld_valid`  in  1  load beat valid.
- `ld_ready`  out  1  load beat accepted when `ld_valid & ld_ready`.
- `ld_data`  in  32  load word.
- `ld_last`  in  1  final beat of the image.
- `reload`  in  1  single-cycle request to restart loading.
- `ld_count`  out  $clog2(Depth)+1  words written since the last load start.
- `ld_overflow`  out  1  sticky: the store filled before `ld_last`.

## Operation

- Two states: LOAD and RUN. There is a write pointer `ptr` of width $clog2(Depth), plus `ld_count`.
- **Reset** (`reset`=0 at an edge):
  - State goes to LOAD with `ptr`=0, `ld_count`=0, `ld_overflow`=0.
  - Store contents are not cleared.
- **LOAD**:
  - Outputs: `halted`=1, `ld_ready`=~`reload`, `i_data`=NOP (32'h0000_0013), `i_fault`=0.
  - Accepted beat: write `mem[ptr]`←`ld_data`, then `ptr`++ and `ld_count`++.
  - Accepted beat with `ld_last`=1: go to RUN.
  - Accepted beat with `ptr`=Depth−1 and `ld_last`=0: go to RUN and set `ld_overflow`.
  - `ptr` never wraps.
- **RUN**:
  - Outputs: `halted`=0, `ld_ready`=0.
  - Compute offset `off` = `i_addr` − `BootVector` as a 32-bit unsigned subtraction.
  - If `off` < Depth·4: `i_data`=`mem[off[$clog2(Depth)+1:2]]` and `i_fault`=0.
  - Otherwise: `i_data`=NOP and `i_fault`=1.
  - `off[1:0]` is ignored; misalignment is detected by the fetch stage.
- **`reload`=1 at an edge** (either state):
  - Next state is LOAD with `ptr`=0, `ld_count`=0, `ld_overflow`=0.
  - In LOAD, `reload` takes priority over a concurrent beat. `ld_ready` is low in that cycle, so no beat is accepted.
- `ld_count` holds its value in RUN.
- Unwritten words read back whatever they last held.

## Timing

- Reset values of outputs:
  - `halted`=1, `ld_ready`=1 (with `reload`=0), `ld_count`=0, `ld_overflow`=0.
  - `i_data`=NOP, `i_fault`=0.
- A write accepted at edge N is readable from cycle N+1 onward. It is first visible externally in RUN.
- Leaving LOAD: after the last/overflow beat at edge N, `halted` falls and `ld_ready` falls in cycle N+1.
- Entering LOAD: after `reload` at edge N, `halted` and `ld_ready` rise in cycle N+1.
- The read path is purely combinational (zero latency). `i_data` and `i_fault` change only with `i_addr` or at state and memory edges.
- `ld_ready` does not depend on `ld_valid`, so there is no combinational loop toward the host.
- Reset mid-load discards progress. The partially written words remain in the store, and the next load starts at word 0.

## Test plan

- **Reset then load:** 3 beats 32'h0050_0093, 32'h0010_8113, 32'h0000_006F (last on beat 3), `BootVector`=0.
  - `halted`=1 through the third beat, then 0.
  - `ld_count`=3.
  - `i_addr`=4 → `i_data`=32'h0010_8113, `i_fault`=0.
- **Backpressure gaps:** `ld_valid` toggled 1,0,1,0,1 with the last beat on the third valid.
  - Exactly 3 words are written, in order.
  - No word is written during gap cycles.
- **Overflow:** `Depth`=4, 5 beats offered with no `ld_last`.
  - After 4 beats: RUN, `ld_overflow`=1, `ld_ready`=0.
  - The 5th beat is never accepted.
  - `i_addr`=12 returns the 4th word.
- **Out-of-range reads:** `BootVector`=32'h0000_1000, `Depth`=16.
  - `i_addr`=32'h0000_0FFC → NOP, `i_fault`=1.
  - `i_addr`=32'h0000_1040 → NOP, `i_fault`=1.
  - `i_addr`=32'h0000_103C → word 15, `i_fault`=0.
- **Reload collision:** in LOAD with `ld_valid`=1 and `reload`=1 in the same cycle.
  - `ld_ready`=0 in that cycle and no write occurs.
  - Next cycle `ld_count`=0 and the next beat writes word 0.
  - Also assert `reload` in RUN: `halted`=1 the next cycle and `i_data`=NOP.
- **Reset mid-load:** `reset`=0 after 2 of 4 beats.
  - `ld_count`=0, `ld_overflow`=0, `halted`=1.
  - A new 2-beat load overwrites words 0–1.
